if_id_queue: RTL and testbench
==============================

# if_id_queue

Instruction queue between the fetch unit and the decode stage of the pipelined MIPS core. It buffers up to DEPTH fetched words, each with its PC+8 value and fetch exception code, so fetch can keep running while decode is stalled. Control-flow redirects (taken branch/jump, eret, interrupt entry) clear it with a single-cycle flush. Decode always sees entries in program order.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- AW, log2(DEPTH), pointer width; derived, never overridden
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries this cycle
- push_valid  in  1  fetch presents an entry
- push_ready  out  1  queue accepts an entry this cycle
- push_instr  in  32  fetched instruction (already 0 on fetch exception)
- push_pc8  in  32  PC+8 of that instruction
- push_exc  in  5  fetch ExcCode (0 none, 4 AdEL)
- pop_valid  out  1  head entry available to decode
- pop_ready  in  1  decode consumes head this cycle
- pop_instr  out  32  head instruction
- pop_pc8  out  32  head PC+8
- pop_exc  out  5  head ExcCode
- count  out  AW+1  entries currently stored
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Storage: circular buffer of DEPTH entries of {instr, pc8, exc}. Write pointer wp and read pointer rp, both AW bits, wrap modulo DEPTH. count is a separate AW+1-bit register.
- Push handshake: push fires when push_valid && push_ready. The entry is written at wp, then wp advances by 1.
- push_ready = !full && !flush. A pop in the same cycle does not free space for a push when full; that push is refused.
- Pop handshake: pop fires when pop_valid && pop_ready. rp advances by 1.
- pop_valid = !empty && !flush. The stored-entry path drives pop_instr/pop_pc8/pop_exc from the entry at rp.
- When pop_valid is 0, pop_instr, pop_pc8 and pop_exc are driven to 0.
- Push and pop in the same cycle: both fire and count is unchanged.
- Entries with nonzero exc are queued and delivered unchanged. The queue never inspects or squashes them.
- Flush: at the next rising edge, wp, rp and count are cleared to 0. Any push or pop offered in the flush cycle is ignored. Stored data need not be cleared.
- Writes into a full queue, and pops from an empty queue, are impossible by construction.

## Timing
- Reset (reset = 0, asynchronous): wp = rp = count = 0.
- Output values while in reset: push_ready = 1, pop_valid = 0, pop_instr/pop_pc8/pop_exc = 0, count = 0, full = 0, empty = 1.
- Without bypass, latency is 1 cycle: an entry pushed at edge N is visible as pop_valid at edge N+1.
- Throughput: one push and one pop per cycle in steady state.
- full, empty and count are registered-state functions, stable for the whole cycle.
- push_ready and pop_valid additionally have a combinational dependency on flush.
- Reset asserted mid-operation discards all entries immediately. First push is accepted on the first edge after reset returns to 1.

## Configuration
- IF_ID_QUEUE_BYPASS_EN defined: when the queue is empty, push_valid = 1, pop_ready = 1 and flush = 0, the push data is forwarded combinationally to the pop outputs.
  - pop_valid = 1 in that cycle; both handshakes fire.
  - Nothing is written; wp, rp and count are unchanged.
  - If pop_ready = 0 in that case, the entry is stored normally.
- IF_ID_QUEUE_BYPASS_EN undefined: no push-to-pop combinational path, minimum latency 1 cycle.

## Test plan
- Reset, then push 0x24080001/0x3008 with pop_ready = 0 -> next cycle pop_valid = 1, pop_instr = 0x24080001, pop_pc8 = 0x3008, count = 1, empty = 0.
- Push 4 entries (pc8 0x3008..0x3014) with pop_ready = 0 -> full = 1, push_ready = 0, fifth push refused; then pop 4 -> pc8 order 0x3008, 0x300C, 0x3010, 0x3014, empty = 1.
- Fill to 3, then push and pop every cycle for 10 cycles -> count stays 3, pointers wrap, program order preserved.
- 2 entries stored, assert flush together with push_valid and pop_ready -> pop_valid = 0 and push_ready = 0 that cycle, count = 0 next cycle, flushed push not stored.
- Push an entry with exc = 4, instr = 0 -> delivered with pop_exc = 4, pop_instr = 0.
- With IF_ID_QUEUE_BYPASS_EN: empty queue, push_valid = pop_ready = 1, push_instr = 0x1000FFFF -> same-cycle pop_valid = 1, pop_instr = 0x1000FFFF, count stays 0. Without the macro -> pop_valid = 0 that cycle, 1 the next.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {instr, pc8, exc} with single-cycle flush.
// Define IF_ID_QUEUE_BYPASS_EN to forward a push straight to the pop outputs when the queue is empty.
module if_id_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [31:0]              push_instr,
  input  logic [31:0]              push_pc8,
  input  logic [4:0]               push_exc,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [31:0]              pop_instr,
  output logic [31:0]              pop_pc8,
  output logic [4:0]               pop_exc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc8_mem   [DEPTH];
  logic [4:0]  exc_mem   [DEPTH];

  logic bypass;
  logic wr_en;
  logic rd_en;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    bypass = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass = empty && push_valid && pop_ready && !flush;
`endif
    push_ready = !full && !flush;
    pop_valid  = (!empty || bypass) && !flush;
    // A bypassed entry completes both handshakes without touching storage.
    wr_en = push_valid && push_ready && !bypass;
    rd_en = pop_valid && pop_ready && !bypass;
  end

  always_comb begin
    pop_instr = '0;
    pop_pc8   = '0;
    pop_exc   = '0;
    if (pop_valid) begin
      if (bypass) begin
        pop_instr = push_instr;
        pop_pc8   = push_pc8;
        pop_exc   = push_exc;
      end else begin
        pop_instr = instr_mem[rp_q];
        pop_pc8   = pc8_mem[rp_q];
        pop_exc   = exc_mem[rp_q];
      end
    end
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (wr_en) wp_d = wp_q + 1'b1;
      if (rd_en) rp_d = rp_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_mem[wp_q] <= push_instr;
      pc8_mem[wp_q]   <= push_pc8;
      exc_mem[wp_q]   <= push_exc;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: cycle model plus scoreboard of queued entries.
// Honours IF_ID_QUEUE_BYPASS_EN the same way the design does.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_instr;
  logic [31:0] push_pc8;
  logic [4:0]  push_exc;
  logic        pop_valid;
  logic        pop_ready;
  logic [31:0] pop_instr;
  logic [31:0] pop_pc8;
  logic [4:0]  pop_exc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  logic [68:0] sb[$];
  int          m_cnt = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_instr (push_instr),
    .push_pc8   (push_pc8),
    .push_exc   (push_exc),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_instr  (pop_instr),
    .pop_pc8    (pop_pc8),
    .pop_exc    (pop_exc),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 after the rising edge; everything is sampled on the falling edge.
  task automatic drive(input logic rs, input logic fl, input logic pv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [4:0] ex, input logic pr);
    @(posedge clk);
    #1;
    reset      = rs;
    flush      = fl;
    push_valid = pv;
    push_instr = ins;
    push_pc8   = pc;
    push_exc   = ex;
    pop_ready  = pr;
    @(negedge clk);
  endtask

  // Cycle model and scoreboard.
  always @(negedge clk) begin
    logic        m_byp, m_pr, m_pv, m_push, m_pop;
    logic [68:0] e;
    if (!reset) begin
      check_eq("rst_push_ready", 32'(push_ready), 32'd1);
      check_eq("rst_pop_valid", 32'(pop_valid), 32'd0);
      check_eq("rst_pop_instr", pop_instr, 32'd0);
      check_eq("rst_pop_pc8", pop_pc8, 32'd0);
      check_eq("rst_pop_exc", 32'(pop_exc), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_empty", 32'(empty), 32'd1);
      sb.delete();
      m_cnt = 0;
    end else begin
      m_byp = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
      m_byp = (m_cnt == 0) && push_valid && pop_ready && !flush;
`endif
      m_pr = (m_cnt != DEPTH) && !flush;
      m_pv = ((m_cnt != 0) || m_byp) && !flush;
      check_eq("push_ready", 32'(push_ready), 32'(m_pr));
      check_eq("pop_valid", 32'(pop_valid), 32'(m_pv));
      check_eq("count", 32'(count), 32'(m_cnt));
      check_eq("full", 32'(full), 32'(m_cnt == DEPTH));
      check_eq("empty", 32'(empty), 32'(m_cnt == 0));
      m_push = push_valid && m_pr;
      m_pop  = m_pv && pop_ready;
      if (m_push) sb.push_back({push_instr, push_pc8, push_exc});
      if (m_pv) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = m_pop ? sb.pop_front() : sb[0];
          check_eq("head_instr", pop_instr, e[68:37]);
          check_eq("head_pc8", pop_pc8, e[36:5]);
          check_eq("head_exc", 32'(pop_exc), 32'(e[4:0]));
        end
      end else begin
        check_eq("idle_instr", pop_instr, 32'd0);
        check_eq("idle_pc8", pop_pc8, 32'd0);
        check_eq("idle_exc", 32'(pop_exc), 32'd0);
      end
      if (flush) begin
        sb.delete();
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    push_instr = '0; push_pc8 = '0; push_exc = '0;
    @(negedge clk);
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0);

    // Single push, visible one cycle later.
    drive(1'b1, 0, 1, 32'h2408_0001, 32'h3008, 5'd0, 0);
    check_eq("t1_pv_same_cycle", 32'(pop_valid), 32'd0);
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    check_eq("t1_pop_valid", 32'(pop_valid), 32'd1);
    check_eq("t1_pop_instr", pop_instr, 32'h2408_0001);
    check_eq("t1_pop_pc8", pop_pc8, 32'h3008);
    check_eq("t1_count", 32'(count), 32'd1);
    check_eq("t1_empty", 32'(empty), 32'd0);
    drive(1'b1, 0, 0, 0, 0, 0, 1);

    // Fill, refuse fifth push (even with a pop offered), drain in order.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 0, 1, 32'h2000_0000 + 32'(i), 32'h3008 + 32'(4 * i), 5'd0, 0);
    drive(1'b1, 0, 1, 32'hdead_beef, 32'h3018, 5'd0, 1);
    check_eq("t2_full", 32'(full), 32'd1);
    check_eq("t2_push_ready", 32'(push_ready), 32'd0);
    check_eq("t2_head_pc8", pop_pc8, 32'h3008);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 0, 0, 0, 0, 0, 1);
      check_eq("t2_order_pc8", pop_pc8, 32'h3008 + 32'(4 * i));
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0);
    check_eq("t2_empty", 32'(empty), 32'd1);

    // Steady state: fill to 3, push and pop every cycle.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 0, 1, 32'h3000_0000 + 32'(i), 32'h4008 + 32'(4 * i), 5'd0, 0);
    for (int i = 3; i < 13; i++) begin
      drive(1'b1, 0, 1, 32'h3000_0000 + 32'(i), 32'h4008 + 32'(4 * i), 5'd0, 1);
      check_eq("t3_count", 32'(count), 32'd3);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 0, 0, 0, 0, 1);

    // Flush with push and pop offered.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 0, 1, 32'h5000_0000 + 32'(i), 32'h5008 + 32'(4 * i), 5'd0, 0);
    drive(1'b1, 1, 1, 32'h5555_5555, 32'h5555, 5'd0, 1);
    check_eq("t4_pop_valid", 32'(pop_valid), 32'd0);
    check_eq("t4_push_ready", 32'(push_ready), 32'd0);
    drive(1'b1, 0, 0, 0, 0, 0, 1);
    check_eq("t4_count", 32'(count), 32'd0);
    check_eq("t4_pop_valid_after", 32'(pop_valid), 32'd0);

    // Exception entry passes through untouched.
    drive(1'b1, 0, 1, 32'h0, 32'h6008, 5'd4, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 1);
    check_eq("t5_pop_exc", 32'(pop_exc), 32'd4);
    check_eq("t5_pop_instr", pop_instr, 32'd0);

    // Push into empty queue with decode ready.
    drive(1'b1, 0, 1, 32'h1000_ffff, 32'h7008, 5'd0, 1);
`ifdef IF_ID_QUEUE_BYPASS_EN
    check_eq("t6_byp_pop_valid", 32'(pop_valid), 32'd1);
    check_eq("t6_byp_pop_instr", pop_instr, 32'h1000_ffff);
    drive(1'b1, 0, 0, 0, 0, 0, 1);
    check_eq("t6_byp_count", 32'(count), 32'd0);
    check_eq("t6_byp_pop_valid_next", 32'(pop_valid), 32'd0);
`else
    check_eq("t6_pop_valid", 32'(pop_valid), 32'd0);
    drive(1'b1, 0, 0, 0, 0, 0, 1);
    check_eq("t6_pop_valid_next", 32'(pop_valid), 32'd1);
    check_eq("t6_pop_instr_next", pop_instr, 32'h1000_ffff);
`endif

    // Reset mid-operation, then first push right after release.
    for (int i = 0; i < 2; i++)
      drive(1'b1, 0, 1, 32'h8000_0000 + 32'(i), 32'h8008 + 32'(4 * i), 5'd0, 0);
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    check_eq("t7_rst_count", 32'(count), 32'd0);
    drive(1'b1, 0, 1, 32'h9000_0001, 32'h9008, 5'd0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 1);
    check_eq("t7_count", 32'(count), 32'd1);
    check_eq("t7_pop_pc8", pop_pc8, 32'h9008);
    drive(1'b1, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
